pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the 4-stage core (IF, ID, EX, MEM).
- Consumes the execute stage's jump, flush, unpause and load-issue outputs, a pause request from decode and the data-memory load-done handshake.
- Drives PC redirect, IF/ID hold and flush, ID/EX bubble insertion, and a pause watchdog.
- Single owner of all stall/flush decisions; no other block may gate pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_hazard_cmp.sv | 19 +
 rtl/pipe_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: state encodings,
// the "no load" mode value and register-address width.
package pipe_ctrl_pkg;

    localparam int XLEN_WIDTH = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] PIPE_ST_RUN       = 2'd0;
    localparam logic [1:0] PIPE_ST_JUMP_WAIT = 2'd1;
    localparam logic [1:0] PIPE_ST_LOAD_WAIT = 2'd2;

    localparam logic [2:0] LOAD_MODE_NONE = 3'b111;

    // True when the EX stage is issuing a load this cycle.
    function automatic logic is_load_issue(input logic [2:0] mode);
        return mode != LOAD_MODE_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Register-dependency comparator: flags an ID source that reads the
// destination of the outstanding load. Writes to x0 never create a hazard.
module pipe_ctrl_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  hit
);

    // Match either used source against a non-zero destination.
    always_comb begin
        hit = (rd != '0) && ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 4-stage core (IF, ID, EX, MEM).
// Sole owner of PC redirect, IF/ID hold/flush, ID/EX bubble and the pause
// watchdog. Optional performance counters are enabled by defining
// PIPE_CTRL_PERF_EN (adds stall_cycles and flush_count outputs).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN          = XLEN_WIDTH,
    parameter int JUMP_WAIT_MAX = 8,
    parameter int CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_pc_jump,
    input  logic [XLEN-1:0]       ex_pc_jump_addr,
    input  logic                  ex_flush,
    input  logic                  ex_unpause,
    input  logic [2:0]            ex_load_mode,
    input  logic [REG_ADDR_W-1:0] ex_load_rd,
    input  logic                  mem_load_done,
    input  logic                  id_pause_req,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_is_mem,
    output logic                  pc_set,
    output logic [XLEN-1:0]       pc_set_addr,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  wd_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic [REG_ADDR_W-1:0] pend_rd_nxt;
    logic                  wd_err_nxt;

    logic redirect;
    logic load_issue;
    logic reg_hazard;
    logic hazard;
    logic wd_fire;

    pipe_ctrl_hazard_cmp u_hazard_cmp (
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rs1_used (id_rs1_used),
        .rs2_used (id_rs2_used),
        .rd       (pend_rd),
        .hit      (reg_hazard)
    );

    // Decode the events that drive every decision this cycle.
    always_comb begin
        redirect   = ex_pc_jump | ex_flush;
        load_issue = is_load_issue(ex_load_mode);
        hazard     = reg_hazard | id_is_mem;
        wd_fire    = (state == PIPE_ST_JUMP_WAIT) && !redirect && !ex_unpause &&
                     (cnt == CNT_W'(JUMP_WAIT_MAX));
    end

    // Control outputs: redirect beats the watchdog, which beats load hazards and pauses.
    always_comb begin
        pc_set       = 1'b0;
        pc_set_addr  = '0;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst) begin
            pc_set      = ex_pc_jump;
            pc_set_addr = ex_pc_jump ? ex_pc_jump_addr : '0;
            if (redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                case (state)
                    PIPE_ST_RUN: begin
                        if (!load_issue && id_pause_req) begin
                            pc_hold    = 1'b1;
                            if_id_hold = 1'b1;
                        end
                    end
                    PIPE_ST_JUMP_WAIT: begin
                        if (!wd_fire) begin
                            pc_hold    = 1'b1;
                            if_id_hold = 1'b1;
                        end
                    end
                    PIPE_ST_LOAD_WAIT: begin
                        if (hazard && !mem_load_done) begin
                            pc_hold      = 1'b1;
                            if_id_hold   = 1'b1;
                            id_ex_bubble = 1'b1;
                        end
                    end
                    default: begin
                        pc_hold = 1'b0;
                    end
                endcase
            end
        end
    end

    // Next-state logic for the sequencing FSM, pause counter and pending load.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_rd_nxt = pend_rd;
        wd_err_nxt  = wd_err;
        case (state)
            PIPE_ST_RUN: begin
                if (load_issue) begin
                    state_nxt   = PIPE_ST_LOAD_WAIT;
                    pend_rd_nxt = ex_load_rd;
                end else if (!redirect && id_pause_req) begin
                    state_nxt = PIPE_ST_JUMP_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PIPE_ST_JUMP_WAIT: begin
                if (redirect || ex_unpause) begin
                    state_nxt = PIPE_ST_RUN;
                end else if (wd_fire) begin
                    state_nxt  = PIPE_ST_RUN;
                    wd_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PIPE_ST_LOAD_WAIT: begin
                if (mem_load_done) begin
                    if (load_issue) begin
                        pend_rd_nxt = ex_load_rd;
                    end else begin
                        state_nxt = PIPE_ST_RUN;
                    end
                end
            end
            default: begin
                state_nxt = PIPE_ST_RUN;
            end
        endcase
    end

    // Register the FSM; reset discards any pending load or pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PIPE_ST_RUN;
            cnt     <= '0;
            pend_rd <= '0;
            wd_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_rd <= pend_rd_nxt;
            wd_err  <= wd_err_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running wrap-around counters of stalled and flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pc_hold) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (if_id_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by a
// randomized run against a behavioural reference model.
module tb_pipe_ctrl;

    localparam int XLEN          = 32;
    localparam int JUMP_WAIT_MAX = 8;
    localparam int CNT_W         = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_pc_jump;
    logic [XLEN-1:0] ex_pc_jump_addr;
    logic            ex_flush;
    logic            ex_unpause;
    logic [2:0]      ex_load_mode;
    logic [4:0]      ex_load_rd;
    logic            mem_load_done;
    logic            id_pause_req;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic            id_is_mem;
    logic            pc_set;
    logic [XLEN-1:0] pc_set_addr;
    logic            pc_hold;
    logic            if_id_hold;
    logic            if_id_flush;
    logic            id_ex_bubble;
    logic            wd_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]     stall_cycles;
    logic [31:0]     flush_count;
`endif

    // {pc_set, pc_hold, if_id_hold, if_id_flush, id_ex_bubble, wd_err}
    logic [5:0] ctl;
    assign ctl = {pc_set, pc_hold, if_id_hold, if_id_flush, id_ex_bubble, wd_err};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pipeline mode, cycles spent waiting, pending rd, watchdog flag.
    int          m_mode;   // 0 = running, 1 = waiting for jump, 2 = waiting for load
    int          m_waited;
    int          m_rd;
    bit          m_wd;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    pipe_ctrl #(
        .XLEN          (XLEN),
        .JUMP_WAIT_MAX (JUMP_WAIT_MAX),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_pc_jump      (ex_pc_jump),
        .ex_pc_jump_addr (ex_pc_jump_addr),
        .ex_flush        (ex_flush),
        .ex_unpause      (ex_unpause),
        .ex_load_mode    (ex_load_mode),
        .ex_load_rd      (ex_load_rd),
        .mem_load_done   (mem_load_done),
        .id_pause_req    (id_pause_req),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_is_mem       (id_is_mem),
        .pc_set          (pc_set),
        .pc_set_addr     (pc_set_addr),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .wd_err          (wd_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst             = 1'b0;
        ex_pc_jump      = 1'b0;
        ex_pc_jump_addr = '0;
        ex_flush        = 1'b0;
        ex_unpause      = 1'b0;
        ex_load_mode    = 3'b111;
        ex_load_rd      = '0;
        mem_load_done   = 1'b0;
        id_pause_req    = 1'b0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_rs1_used     = 1'b0;
        id_rs2_used     = 1'b0;
        id_is_mem       = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs derived from the controller rules for the current inputs.
    function automatic void model_outputs(output logic [5:0] e_ctl, output logic [XLEN-1:0] e_addr);
        bit flush_now  = ex_pc_jump || ex_flush;
        bit load_now   = ex_load_mode != 3'b111;
        bit dep        = (m_rd != 0) &&
                         ((id_rs1_used && int'(id_rs1) == m_rd) || (id_rs2_used && int'(id_rs2) == m_rd));
        bit must_stall = dep || id_is_mem;
        bit hold = 0;
        bit bub  = 0;
        if (rst) begin
            e_ctl  = {5'b00000, m_wd};
            e_addr = '0;
            return;
        end
        if (flush_now) begin
            bub = 1;
        end else if (m_mode == 1) begin
            hold = !(m_waited == JUMP_WAIT_MAX && !ex_unpause);
        end else if (m_mode == 2) begin
            if (must_stall && !mem_load_done) begin
                hold = 1;
                bub  = 1;
            end
        end else if (!load_now && id_pause_req) begin
            hold = 1;
        end
        e_ctl  = {ex_pc_jump, hold, hold, flush_now, bub, m_wd};
        e_addr = ex_pc_jump ? ex_pc_jump_addr : '0;
    endfunction

    // Advance the reference model across one clock edge.
    function automatic void model_advance();
        logic [5:0]      e_ctl;
        logic [XLEN-1:0] e_addr;
        bit flush_now = ex_pc_jump || ex_flush;
        bit load_now  = ex_load_mode != 3'b111;
        model_outputs(e_ctl, e_addr);
        if (rst) begin
            m_mode = 0; m_waited = 0; m_rd = 0; m_wd = 0;
            m_stall = 0; m_flush = 0;
            return;
        end
        if (e_ctl[4]) m_stall = m_stall + 32'd1;
        if (e_ctl[2]) m_flush = m_flush + 32'd1;
        if (m_mode == 0) begin
            if (load_now) begin
                m_mode = 2; m_rd = int'(ex_load_rd);
            end else if (!flush_now && id_pause_req) begin
                m_mode = 1; m_waited = 0;
            end
        end else if (m_mode == 1) begin
            if (flush_now || ex_unpause) m_mode = 0;
            else if (m_waited == JUMP_WAIT_MAX) begin
                m_wd = 1; m_mode = 0;
            end else m_waited++;
        end else if (mem_load_done) begin
            if (load_now) m_rd = int'(ex_load_rd);
            else m_mode = 0;
        end
    endfunction

    task automatic test_reset();
        idle_inputs();
        ex_load_mode = 3'b010;
        ex_load_rd   = 5'd5;
        cyc();
        idle_inputs();
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        rst = 1'b1; ex_pc_jump = 1'b1; ex_pc_jump_addr = 32'hDEAD_BEEF; ex_flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pc_set_addr, ctl[5:1]} !== {32'h0, 5'b00000}) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs cycle %0d got ctl=%b addr=%h want ctl=00000x addr=0", i, ctl, pc_set_addr);
            end
            cyc();
        end
        rst = 1'b0; ex_pc_jump = 1'b0; ex_flush = 1'b0; ex_pc_jump_addr = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (ctl !== 6'b000000) begin
                n_fail++;
                $display("[TB] FAIL reset_state cycle %0d got ctl=%b want 000000", i, ctl);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        idle_inputs();
        ex_pc_jump = 1'b1; ex_pc_jump_addr = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b100110 || pc_set_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("[TB] FAIL redirect_jump got ctl=%b addr=%h want ctl=100110 addr=00000100", ctl, pc_set_addr);
        end
        cyc();
        ex_pc_jump = 1'b0; ex_flush = 1'b1; id_pause_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b000110 || pc_set_addr !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL redirect_flush got ctl=%b addr=%h want ctl=000110 addr=0", ctl, pc_set_addr);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++;
            $display("[TB] FAIL redirect_after got ctl=%b want 000000", ctl);
        end
        cyc();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_load_mode = 3'b010; ex_load_rd = 5'd5;
        cyc();
        idle_inputs();
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_load_done = (k == 3);
            @(negedge clk);
            n_checks++;
            if (ctl !== ((k < 3) ? 6'b011010 : 6'b000000)) begin
                n_fail++;
                $display("[TB] FAIL load_use cycle %0d got ctl=%b want %b", k, ctl, (k < 3) ? 6'b011010 : 6'b000000);
            end
            cyc();
        end
        mem_load_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++;
            $display("[TB] FAIL load_use_release got ctl=%b want 000000", ctl);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_x0_and_mem();
        idle_inputs();
        ex_load_mode = 3'b000; ex_load_rd = 5'd0;
        cyc();
        idle_inputs();
        id_rs1 = 5'd0; id_rs1_used = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (ctl !== 6'b000000) begin
                n_fail++;
                $display("[TB] FAIL x0_no_stall cycle %0d got ctl=%b want 000000", k, ctl);
            end
            cyc();
        end
        mem_load_done = 1'b1;
        cyc();
        mem_load_done = 1'b0;
        ex_load_mode = 3'b000;
        cyc();
        ex_load_mode = 3'b111;
        id_is_mem = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex_flush      = (k == 1);
            mem_load_done = (k == 3);
            @(negedge clk);
            n_checks++;
            if (ctl !== ((k == 1) ? 6'b000110 : (k < 3) ? 6'b011010 : 6'b000000)) begin
                n_fail++;
                $display("[TB] FAIL mem_stall cycle %0d got ctl=%b want %b", k, ctl,
                         (k == 1) ? 6'b000110 : (k < 3) ? 6'b011010 : 6'b000000);
            end
            cyc();
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_jal_pause();
        int holds = 0;
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            id_pause_req = (k == 0);
            ex_unpause   = (k == 2);
            @(negedge clk);
            if (pc_hold === 1'b1) holds++;
            n_checks++;
            if (ctl !== ((k < 3) ? 6'b011000 : 6'b000000)) begin
                n_fail++;
                $display("[TB] FAIL jal_pause cycle %0d got ctl=%b want %b", k, ctl, (k < 3) ? 6'b011000 : 6'b000000);
            end
            cyc();
        end
        n_checks++;
        if (holds !== 3) begin
            n_fail++;
            $display("[TB] FAIL jal_hold_count got %0d want 3", holds);
        end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        idle_inputs();
        id_pause_req = 1'b1;
        cyc();
        id_pause_req = 1'b0;
        for (int k = 0; k <= JUMP_WAIT_MAX; k++) begin
            @(negedge clk);
            n_checks++;
            if (ctl !== ((k < JUMP_WAIT_MAX) ? 6'b011000 : 6'b000000)) begin
                n_fail++;
                $display("[TB] FAIL watchdog_wait cycle %0d got ctl=%b want %b", k, ctl,
                         (k < JUMP_WAIT_MAX) ? 6'b011000 : 6'b000000);
            end
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            ex_pc_jump = (k == 1); ex_pc_jump_addr = 32'h0000_0040;
            @(negedge clk);
            n_checks++;
            if (ctl !== ((k == 1) ? 6'b100111 : 6'b000001)) begin
                n_fail++;
                $display("[TB] FAIL watchdog_sticky cycle %0d got ctl=%b want %b", k, ctl, (k == 1) ? 6'b100111 : 6'b000001);
            end
            cyc();
        end
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wd_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL watchdog_clear got wd_err=%b want 0", wd_err);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [5:0]      e_ctl;
        logic [XLEN-1:0] e_addr;
        for (int i = 0; i < 800; i++) begin
            rst             = (i == 0) || ($urandom_range(0, 79) == 0);
            ex_pc_jump      = ($urandom_range(0, 7) == 0);
            ex_pc_jump_addr = $urandom;
            ex_flush        = ($urandom_range(0, 9) == 0);
            ex_unpause      = ($urandom_range(0, 7) == 0);
            ex_load_mode    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
            ex_load_rd      = 5'($urandom_range(0, 7));
            mem_load_done   = ($urandom_range(0, 2) == 0);
            id_pause_req    = ($urandom_range(0, 3) == 0);
            id_rs1          = 5'($urandom_range(0, 7));
            id_rs2          = 5'($urandom_range(0, 7));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            id_is_mem       = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            if (i > 0) begin
                model_outputs(e_ctl, e_addr);
                n_checks++;
                if ({pc_set_addr, ctl} !== {e_addr, e_ctl}) begin
                    n_fail++;
                    $display("[TB] FAIL random cycle %0d got ctl=%b addr=%h want ctl=%b addr=%h", i, ctl, pc_set_addr, e_ctl, e_addr);
                end
`ifdef PIPE_CTRL_PERF_EN
                n_checks++;
                if (stall_cycles !== m_stall || flush_count !== m_flush) begin
                    n_fail++;
                    $display("[TB] FAIL perf cycle %0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                             i, stall_cycles, flush_count, m_stall, m_flush);
                end
`endif
            end
            @(posedge clk);
            model_advance();
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_redirect();
        test_load_use();
        test_x0_and_mem();
        test_jal_pause();
        test_watchdog();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
